// File: rtl/regwb_pkg.sv
// Shared types for the register-file write-back controller.
// wb_req_t carries one pending register write (destination + data).
package regwb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/regwb_fifo.sv
// Synchronous FIFO of write-back requests; no fall-through, sync active-low reset.
// Caller must not push when full nor pop when empty.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_req;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU vs buffered LSU results onto the regfile port
// and keeps the busy scoreboard. Optional forwarding ports under REGWB_BYPASS_EN.
module regfile_wb_ctrl
    import regwb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_W,  // must equal WB_DATA_W
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    output logic                  wr_en,
    output logic [4:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REGS-1:0]   busy
`ifdef REGWB_BYPASS_EN
    ,
    input  logic [4:0]            byp_addr1,
    input  logic [4:0]            byp_addr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data1,
    output logic [DATA_WIDTH-1:0] byp_data2
`endif
);

    wb_req_t push_req, head;
    logic    fifo_full, fifo_empty, push, pop;

    logic                  wr_en_q, wr_en_d;
    logic [4:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [4:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;

    assign lsu_ready = reset && !fifo_full;
    assign push      = lsu_valid && lsu_ready;
    assign pop       = !alu_valid && !fifo_empty;
    assign push_req  = '{rd: lsu_rd, data: lsu_data};

    regwb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_req(push_req),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        sel_valid = alu_valid || pop;
        sel_rd    = alu_valid ? alu_rd : head.rd;
        sel_data  = alu_valid ? alu_data : head.data;
        wr_en_d   = sel_valid && (sel_rd != '0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // x0 requests are consumed without disturbing the held address/data.
        if (wr_en_d) begin
            wr_addr_d = sel_rd;
            wr_data_d = sel_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (pop && head.rd != '0) busy_d[head.rd] = 1'b0;
        // Issue applied after clear so a same-cycle set wins.
        if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

`ifdef REGWB_BYPASS_EN
    assign byp_hit1  = wr_en_q && (wr_addr_q == byp_addr1) && (byp_addr1 != '0);
    assign byp_hit2  = wr_en_q && (wr_addr_q == byp_addr2) && (byp_addr2 != '0);
    assign byp_data1 = wr_data_q;
    assign byp_data2 = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (default build, no forwarding ports).
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd;
    logic [31:0] alu_data, lsu_data;
    logic        lsu_ready, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd   (lsu_rd),
        .lsu_data (lsu_data),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        step();
        step();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready_low", 64'(lsu_ready), 64'd0);
        reset = 1'b1;
        step();
        check("ready_after_rst", 64'(lsu_ready), 64'd1);

        // 1: ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        check("alu_wr_en", 64'(wr_en), 64'd1);
        check("alu_wr_addr", 64'(wr_addr), 64'd5);
        check("alu_wr_data", 64'(wr_data), 64'hDEADBEEF);
        step();
        check("idle_wr_en", 64'(wr_en), 64'd0);
        check("idle_hold_addr", 64'(wr_addr), 64'd5);
        check("idle_hold_data", 64'(wr_data), 64'hDEADBEEF);

        // 2: ALU vs FIFO head conflict
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        step();
        lsu_valid = 1'b0;
        check("nofall_wr_en", 64'(wr_en), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        step();
        alu_valid = 1'b0;
        check("conf_c1_addr", 64'(wr_addr), 64'd3);
        check("conf_c1_data", 64'(wr_data), 64'h33);
        step();
        check("conf_c2_en", 64'(wr_en), 64'd1);
        check("conf_c2_addr", 64'(wr_addr), 64'd7);
        check("conf_c2_data", 64'(wr_data), 64'h77);
        step();
        check("conf_done_en", 64'(wr_en), 64'd0);

        // 3: fill FIFO while ALU blocks pops, then drain in order
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_rd = 5'(10 + i); lsu_data = 32'hA0 + 32'(i);
            step();
            if (i == 2) check("ready_at_3", 64'(lsu_ready), 64'd1);
        end
        check("full_ready_low", 64'(lsu_ready), 64'd0);
        check("full_alu_addr", 64'(wr_addr), 64'd1);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_en", 64'(wr_en), 64'd1);
            check("drain_addr", 64'(wr_addr), 64'(10 + i));
            check("drain_data", 64'(wr_data), 64'(32'hA0 + 32'(i)));
        end
        step();
        check("drained_en", 64'(wr_en), 64'd0);
        check("drained_ready", 64'(lsu_ready), 64'd1);

        // 4: scoreboard set then clear on LSU commit
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        check("sb_set", 64'(busy), 64'h200);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        lsu_valid = 1'b0;
        check("sb_buffered", 64'(busy), 64'h200);
        step();
        check("sb_commit_en", 64'(wr_en), 64'd1);
        check("sb_commit_addr", 64'(wr_addr), 64'd9);
        check("sb_clear", 64'(busy), 64'd0);

        // 5: same-cycle set and clear of x9 -> set wins
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h98;
        step();
        lsu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        check("race_en", 64'(wr_en), 64'd1);
        check("race_data", 64'(wr_data), 64'h98);
        check("race_busy", 64'(busy), 64'h200);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0;
        check("sb_x0_ignored", 64'(busy), 64'h200);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h44;
        step();
        alu_valid = 1'b0;
        check("alu_keeps_busy", 64'(busy), 64'h200);

        // 6: ALU to x0, then reset with buffered entries
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step();
        check("x0_no_write", 64'(wr_en), 64'd0);
        check("x0_hold_data", 64'(wr_data), 64'h44);
        alu_rd = 5'd2; alu_data = 32'h22;
        lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lsu_rd = 5'(20 + i); lsu_data = 32'hC0 + 32'(i);
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        reset = 1'b0;
        step();
        check("mid_rst_en", 64'(wr_en), 64'd0);
        check("mid_rst_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_data", 64'(wr_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(lsu_ready), 64'd0);
        reset = 1'b1;
        step();
        check("post_rst_empty1", 64'(wr_en), 64'd0);
        step();
        check("post_rst_empty2", 64'(wr_en), 64'd0);
        check("post_rst_ready", 64'(lsu_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
